// File: rtl/wb_burst_sram.sv
// Wishbone B3 slave RAM with classic, incrementing and wrapping burst support.
// Registered reads, byte-lane writes, error termination for out-of-span accesses.
module wb_burst_sram #(
   parameter int          dw                 = 32,
   parameter int          aw                 = 32,
   parameter int unsigned mem_span           = 32'h0000_0400,
   parameter int          adr_width_for_span = 11
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic [aw-1:0] wb_adr_i,
   input  logic [1:0]    wb_bte_i,
   input  logic [2:0]    wb_cti_i,
   input  logic          wb_cyc_i,
   input  logic [dw-1:0] wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          wb_rty_o,
   output logic [dw-1:0] wb_dat_o
);

   // bw carries one extra bit over the memory index so a burst running off
   // the end of the span is detectable as an out-of-range word index.
   localparam int bw    = adr_width_for_span - 2;
   localparam int mw    = adr_width_for_span - 3;
   localparam int words = int'(mem_span / 4);
   localparam logic [aw-1:0] span_b = aw'(mem_span);
   localparam logic [bw-1:0] span_w = bw'(words);

   typedef enum logic [1:0] {IDLE, CLASSIC_ACK, BURST} state_t;

   state_t        state, state_nxt;
   logic [bw-1:0] burst_adr, burst_adr_nxt, nxt, word;
   logic [mw-1:0] rd_idx, wr_idx;
   logic          req, in_range, nxt_in_range;
   logic          ack_nxt, err_nxt, rd_en, wr_en;
   logic [dw-1:0] mem [0:words-1];

   assign req          = wb_cyc_i & wb_stb_i;
   assign word         = wb_adr_i[adr_width_for_span-1:2];
   assign in_range     = wb_adr_i < span_b;
   assign nxt_in_range = nxt < span_w;
   assign wb_rty_o     = 1'b0;

   // Wrapping bursts advance only the low bits; the block base stays put.
   always_comb begin
      nxt = burst_adr + bw'(1);
      case (wb_bte_i)
         2'b01:   nxt = {burst_adr[bw-1:2], burst_adr[1:0] + 2'd1};
         2'b10:   nxt = {burst_adr[bw-1:3], burst_adr[2:0] + 3'd1};
         2'b11:   nxt = {burst_adr[bw-1:4], burst_adr[3:0] + 4'd1};
         default: ;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      burst_adr_nxt = burst_adr;
      ack_nxt       = 1'b0;
      err_nxt       = 1'b0;
      rd_en         = 1'b0;
      rd_idx        = word[mw-1:0];
      wr_en         = 1'b0;
      wr_idx        = word[mw-1:0];
      case (state)
         IDLE: begin
            if (req) begin
               if (!in_range) begin
                  err_nxt = 1'b1;
               end else begin
                  ack_nxt = 1'b1;
                  rd_en   = 1'b1;
                  if (wb_cti_i == 3'b010) begin
                     state_nxt     = BURST;
                     burst_adr_nxt = word;
                  end else begin
                     state_nxt = CLASSIC_ACK;
                  end
               end
            end
         end
         CLASSIC_ACK: begin
            wr_en     = req & wb_we_i & in_range;
            state_nxt = IDLE;
         end
         BURST: begin
            // Address comes from burst_adr; wb_adr_i is ignored after the first beat.
            wr_en     = req & wb_we_i;
            wr_idx    = burst_adr[mw-1:0];
            state_nxt = IDLE;
            if (req && wb_cti_i == 3'b010) begin
               if (nxt_in_range) begin
                  ack_nxt       = 1'b1;
                  rd_en         = 1'b1;
                  rd_idx        = nxt[mw-1:0];
                  burst_adr_nxt = nxt;
                  state_nxt     = BURST;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         burst_adr <= '0;
         wb_ack_o  <= 1'b0;
         wb_err_o  <= 1'b0;
         wb_dat_o  <= '0;
      end else begin
         state     <= state_nxt;
         burst_adr <= burst_adr_nxt;
         wb_ack_o  <= ack_nxt;
         wb_err_o  <= err_nxt;
         if (rd_en) wb_dat_o <= mem[rd_idx];
      end
   end

   // Contents survive reset; a write coinciding with reset is dropped.
   always_ff @(posedge wb_clk_i) begin
      if (wr_en && !wb_rst_i) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) mem[wr_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wb_burst_sram.sv
// Directed bench for wb_burst_sram: byte-lane memory model plus a read-data
// scoreboard filled when a read beat is driven and drained when it is acked.
module tb_wb_burst_sram;

   logic        clk = 1'b0;
   logic        rst, cyc, stb, we;
   logic [31:0] adr, dat_w, dat_r;
   logic [1:0]  bte;
   logic [2:0]  cti;
   logic [3:0]  sel;
   logic        ack, err, rty;

   logic [31:0] mdl [0:255];
   logic [31:0] sb [$];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   wb_burst_sram dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_bte_i(bte),
      .wb_cti_i(cti), .wb_cyc_i(cyc), .wb_dat_i(dat_w), .wb_sel_i(sel),
      .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(ack), .wb_err_o(err),
      .wb_rty_o(rty), .wb_dat_o(dat_r)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_rd(input string tag);
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: observed read %h with empty scoreboard, expected a pending read", tag, dat_r);
      end else begin
         chk({tag, " data"}, dat_r, sb.pop_front());
      end
   endtask

   task automatic idle_bus();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      cti = 3'b000; bte = 2'b00; sel = 4'h0;
   endtask

   task automatic mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) mdl[a[9:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   function automatic logic [31:0] badr(input logic [31:0] s, input logic [1:0] b, input int k);
      logic [31:0] m;
      case (b)
         2'b01:   m = 32'd16;
         2'b10:   m = 32'd32;
         2'b11:   m = 32'd64;
         default: m = 32'd0;
      endcase
      if (m == 0) return s + 32'(4 * k);
      return (s & ~(m - 1)) | ((s + 32'(4 * k)) & (m - 1));
   endfunction

   // In-range classic access with stb held through the ack cycle.
   task automatic classic(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp, input string tag);
      adr = a; dat_w = d; sel = s; we = w; cti = 3'b000; bte = 2'b00;
      cyc = 1'b1; stb = 1'b1;
      if (!w) sb.push_back(exp);
      @(posedge clk); #1;
      chk({tag, " ack"}, 32'(ack), 32'd1);
      chk({tag, " err"}, 32'(err), 32'd0);
      if (!w) chk_rd(tag);
      @(posedge clk); #1;
      if (w) mdl_wr(a, d, s);
      chk({tag, " ack gap"}, 32'(ack), 32'd0);
      idle_bus();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
      classic(1'b1, a, d, s, 32'd0, tag);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      classic(1'b0, a, 32'd0, 4'hF, exp, tag);
   endtask

   task automatic oor(input bit w, input logic [31:0] a, input string tag);
      adr = a; dat_w = 32'h5555_AAAA; sel = 4'hF; we = w; cti = 3'b000;
      cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      chk({tag, " err"}, 32'(err), 32'd1);
      chk({tag, " ack"}, 32'(ack), 32'd0);
      idle_bus();
      @(posedge clk); #1;
      chk({tag, " err drop"}, 32'(err), 32'd0);
   endtask

   task automatic burst(input bit w, input logic [31:0] start, input int n,
                        input logic [1:0] b, input logic [31:0] seed, input string tag);
      logic [31:0] a;
      cyc = 1'b1; stb = 1'b1; we = w; bte = b; sel = 4'hF;
      for (int k = 0; k < n; k++) begin
         a = badr(start, b, k);
         adr = a; dat_w = seed + 32'(k);
         cti = (k == n - 1) ? 3'b111 : 3'b010;
         if (!w) sb.push_back(mdl[a[9:2]]);
         if (k == 0) begin @(posedge clk); #1; end
         chk({tag, " beat ack"}, 32'(ack), 32'd1);
         chk({tag, " beat err"}, 32'(err), 32'd0);
         if (!w) chk_rd(tag);
         else    mdl_wr(a, seed + 32'(k), 4'hF);
         @(posedge clk); #1;
      end
      chk({tag, " end ack"}, 32'(ack), 32'd0);
      idle_bus();
   endtask

   initial begin
      rst = 1'b1; adr = '0; dat_w = '0;
      idle_bus();
      repeat (3) @(posedge clk);
      #1;
      chk("reset ack", 32'(ack), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset rty", 32'(rty), 32'd0);
      chk("reset dat", dat_r, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) wr(32'(4 * i), $urandom(), 4'hF, "init lo");
      for (int i = 0; i < 8; i++)  wr(32'h100 + 32'(4 * i), $urandom(), 4'hF, "init mid");
      wr(32'h140, 32'h0BAD_F00D, 4'hF, "init 140");
      wr(32'h3FC, $urandom(), 4'hF, "init top");

      wr(32'h10, 32'hDEAD_BEEF, 4'hF, "classic wr");
      rd(32'h10, 32'hDEAD_BEEF, "classic rd");

      wr(32'h20, 32'h1122_3344, 4'hF, "lane base");
      wr(32'h20, 32'hAABB_CCDD, 4'b0101, "lane wr");
      rd(32'h20, 32'h11BB_33DD, "lane rd");

      burst(1'b0, 32'h100, 4, 2'b00, 32'd0, "linear rd");
      burst(1'b0, 32'h18, 4, 2'b01, 32'd0, "wrap4 rd");
      burst(1'b0, 32'h08, 16, 2'b11, 32'd0, "wrap16 rd");

      burst(1'b1, 32'h3C, 8, 2'b10, 32'd0, "wrap8 wr");
      rd(32'h20, 32'd1, "wrap8 wrapped");
      rd(32'h3C, 32'd0, "wrap8 first");
      for (int i = 0; i < 8; i++)
         rd(32'h20 + 32'(4 * i), mdl[8 + i], "wrap8 block");
      rd(32'h1C, mdl[7], "wrap8 below");

      oor(1'b1, 32'h400, "oor wr");
      rd(32'h0, mdl[0], "oor no alias");
      oor(1'b0, 32'h800, "oor rd");

      // Linear burst stepping off the end of the span.
      adr = 32'h3FC; cti = 3'b010; bte = 2'b00; we = 1'b0; sel = 4'hF;
      cyc = 1'b1; stb = 1'b1;
      sb.push_back(mdl[8'hFF]);
      @(posedge clk); #1;
      chk("cross ack", 32'(ack), 32'd1);
      chk_rd("cross");
      adr = 32'h400;
      @(posedge clk); #1;
      chk("cross err", 32'(err), 32'd1);
      chk("cross no ack", 32'(ack), 32'd0);
      idle_bus();
      @(posedge clk); #1;
      chk("cross idle err", 32'(err), 32'd0);
      chk("cross idle ack", 32'(ack), 32'd0);

      // Cycle dropped during the second beat of an intended 8-beat burst.
      adr = 32'h100; cti = 3'b010; bte = 2'b00; we = 1'b0; sel = 4'hF;
      cyc = 1'b1; stb = 1'b1;
      sb.push_back(mdl[8'h40]);
      @(posedge clk); #1;
      chk("abort b0 ack", 32'(ack), 32'd1);
      chk_rd("abort b0");
      adr = 32'h104;
      sb.push_back(mdl[8'h41]);
      @(posedge clk); #1;
      chk("abort b1 ack", 32'(ack), 32'd1);
      chk_rd("abort b1");
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      chk("abort ack drop", 32'(ack), 32'd0);
      idle_bus();
      rd(32'h108, mdl[8'h42], "abort then rd");

      // Reset lands on the ack cycle of a write burst's first beat.
      adr = 32'h140; dat_w = 32'hCAFE_F00D; cti = 3'b010; bte = 2'b00;
      we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      chk("rst burst ack", 32'(ack), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst burst ack drop", 32'(ack), 32'd0);
      chk("rst burst err", 32'(err), 32'd0);
      chk("rst burst dat", dat_r, 32'd0);
      rst = 1'b0;
      idle_bus();
      @(posedge clk); #1;
      rd(32'h140, 32'h0BAD_F00D, "rst write dropped");

      chk("rty tied", 32'(rty), 32'd0);
      chk("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_burst_sram.md
Name: wb_burst_sram

Overview:
- Single-port Wishbone B3 slave RAM. Consumes the arbitrated master bus produced by the two-master RAM arbiter.
- Supports classic cycles plus incrementing and wrapping bursts, driven by cti/bte, with byte-lane writes.
- Registered reads. Out-of-span accesses are errored.
- Sits directly below the arbiter as the on-chip RAM it serves.

Parameters:
- dw, 32: data width. Only 32 is supported; sel is 4 bits.
- aw, 32: address width.
- mem_span, 32'h0000_0400: memory size in bytes; a multiple of 4.
- adr_width_for_span, 11: bits used for internal word/byte addressing; log2(mem_span)+1.

Ports:
- wb_clk_i  in  1  clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wb_adr_i  in  aw  byte address; bits [1:0] are ignored.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; all others are treated as 000.
- wb_cyc_i  in  1  bus cycle valid.
- wb_dat_i  in  dw  write data.
- wb_sel_i  in  4  byte enables; bit n covers [8n+7:8n].
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination (out-of-span).
- wb_rty_o  out  1  retry; tied 0.
- wb_dat_o  out  dw  read data; valid when wb_ack_o=1.

Behaviour:
- Reset:
  - wb_ack_o=0, wb_err_o=0, wb_rty_o=0, wb_dat_o=0.
  - FSM=IDLE; burst address register=0.
  - Memory contents are not cleared.
- Request: req = wb_cyc_i & wb_stb_i.
- Word index = wb_adr_i[adr_width_for_span-1:2]. An access is in range when the full byte address < mem_span.
- FSM states: IDLE, CLASSIC_ACK, BURST.
- IDLE:
  - req & in range & cti!=010: next cycle ack=1, dat_o=mem[word]; go to CLASSIC_ACK.
  - req & in range & cti==010: next cycle ack=1, dat_o=mem[word]; burst_adr<=word; go to BURST.
  - req & out of range: next cycle err=1 for one cycle, ack=0, no write; stay IDLE.
- CLASSIC_ACK:
  - ack is high this cycle.
  - If wb_we_i, write wb_dat_i into mem[word] on the enabled byte lanes.
  - Next cycle ack=0; return to IDLE even if stb is still high. A classic access is one beat per 2 cycles.
- BURST (ack=1 this cycle):
  - If wb_we_i, write wb_dat_i into mem[burst_adr] on the sel lanes.
  - Next address nxt:
    - bte=00: burst_adr+1.
    - bte=01/10/11: low 2/3/4 bits increment modulo 4/8/16; upper bits held.
  - req & cti==010 & nxt in range: next cycle ack=1, dat_o=mem[nxt], burst_adr<=nxt; stay in BURST. Zero wait states.
  - req & cti==010 & nxt out of range: next cycle err=1, ack=0; go to IDLE.
  - cti==111, or stb=0, or cyc=0: next cycle ack=0; go to IDLE. The beat acked in the current cycle is complete.
  - The master supplies wb_adr_i each beat; the slave uses burst_adr and ignores wb_adr_i after the first beat.
- Writes never occur on an err cycle or when ack=0.
- ack and err are never high in the same cycle.
- Reads:
  - Registered: memory is read on the request/next-address edge, so dat_o is aligned with ack.
  - Read-during-write to the same word returns the old data.
  - wb_dat_o holds its last value when ack=0.
- Reset asserted mid-burst: next cycle ack=0 and FSM=IDLE. Any write in the reset cycle is suppressed.
- cyc drop mid-burst (e.g. arbiter switching masters) returns the FSM to IDLE in one cycle. The next request starts a fresh access from wb_adr_i.

Test Plan:
- Classic write then read: write adr 0x10, dat 0xDEADBEEF, sel 1111, stb held → ack pulses 1 cycle, then 0 for 1 cycle. Read adr 0x10 → ack with dat_o 0xDEADBEEF one cycle after stb.
- Byte-lane write: mem[0x20]=0x11223344; write 0xAABBCCDD with sel 0101 → readback 0x11BB33DD.
- Linear burst read: adr 0x100, cti 010 ×3 then 111, bte 00 → ack high 4 consecutive cycles, returning words 0x100, 0x104, 0x108, 0x10C. ack=0 the cycle after the 111 beat.
- Wrap4 burst read: start adr 0x18, bte 01, 4 beats → addresses 0x18, 0x1C, 0x10, 0x14.
- Wrap8 burst write: start 0x3C, data 0..7, bte 10 → readback shows the burst wrapping within the 32-byte block 0x20-0x3F.
- Out-of-range: adr 0x400 (mem_span=0x400) → err=1 one cycle, ack=0, no write.
- Linear burst crossing 0x3FC→0x400 → ack at 0x3FC, then err, then IDLE.
- Abort: cyc=0 in the 2nd beat of an 8-beat burst → ack=0 next cycle. A new classic read then returns the correct data.
- Reset mid-burst → ack=0 next cycle; the write in the reset cycle is suppressed.
